// File: rtl/uart_matrix_tx_streamer.sv
// Streams a ROWS x COLS result matrix out of a synchronous-read RAM through the UART
// transmitter as: header byte, element bytes MSB first in row-major order, XOR checksum.
module uart_matrix_tx_streamer #(
    parameter int          ROWS   = 4,
    parameter int          COLS   = 4,
    parameter int          ELEM_W = 16,
    parameter int          ADDR_W = 4,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [ELEM_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       N_ELEMS   = ROWS * COLS;
    localparam int unsigned       BYTES     = ELEM_W / 8;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_ELEMS - 1);
    localparam logic [1:0]        LAST_BYTE = 2'(BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, HDR, FETCH, LATCH, SEND, WAIT_HI, WAIT_LO, NEXT, CSUM, FIN
    } state_t;

    // Which part of the frame the byte in flight belongs to; steers NEXT.
    typedef enum logic [1:0] {
        PH_HDR, PH_ELEM, PH_CSUM
    } phase_t;

    state_t            state;
    phase_t            phase;
    logic [ADDR_W-1:0] index;
    logic [1:0]        byte_cnt;
    logic [ELEM_W-1:0] shift_reg;
    logic [7:0]        checksum;
    logic [7:0]        cur_byte;

    assign cur_byte = shift_reg[ELEM_W-1 -: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= PH_HDR;
            index     <= '0;
            byte_cnt  <= '0;
            shift_reg <= '0;
            checksum  <= '0;
            rd_addr   <= '0;
            rd_en     <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_en    <= 1'b0;
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HDR;
                        phase    <= PH_HDR;
                        busy     <= 1'b1;
                        index    <= '0;
                        checksum <= '0;
                    end
                end
                HDR: begin
                    shift_reg               <= '0;
                    shift_reg[ELEM_W-1 -: 8] <= HEADER;
                    state                   <= SEND;
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    shift_reg <= rd_data;
                    byte_cnt  <= LAST_BYTE;
                    state     <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= cur_byte;
                        tx_start <= 1'b1;
                        if (phase == PH_ELEM)
                            checksum <= checksum ^ cur_byte;
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: if (tx_busy) state <= WAIT_LO;
                WAIT_LO: if (!tx_busy) state <= NEXT;
                NEXT: begin
                    case (phase)
                        PH_HDR: begin
                            phase   <= PH_ELEM;
                            rd_addr <= index;
                            rd_en   <= 1'b1;
                            state   <= FETCH;
                        end
                        PH_ELEM: begin
                            if (byte_cnt != '0) begin
                                shift_reg <= shift_reg << 8;
                                byte_cnt  <= byte_cnt - 1'b1;
                                state     <= SEND;
                            end else if (index != LAST_IDX) begin
                                index   <= index + 1'b1;
                                rd_addr <= index + 1'b1;
                                rd_en   <= 1'b1;
                                state   <= FETCH;
                            end else begin
                                state <= CSUM;
                            end
                        end
                        default: begin
                            // done/busy change on entry to FIN so a start seen
                            // alongside the done pulse lands in FIN and is dropped.
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end
                    endcase
                end
                CSUM: begin
                    shift_reg               <= '0;
                    shift_reg[ELEM_W-1 -: 8] <= checksum;
                    phase                   <= PH_CSUM;
                    state                   <= SEND;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_matrix_tx_streamer.sv
// Bench for uart_matrix_tx_streamer: a 2x2x16 instance and a 1x3x8 instance, each with
// a RAM model, a UART busy model and a byte-level reference of the expected frame.
module tb_uart_matrix_tx_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start_a, rd_en_a, tx_start_a, tx_busy_a, busy_a, done_a;
    logic [1:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [7:0]  tx_data_a;

    logic        start_b, rd_en_b, tx_start_b, tx_busy_b, busy_b, done_b;
    logic [1:0]  rd_addr_b;
    logic [7:0]  rd_data_b;
    logic [7:0]  tx_data_b;

    uart_matrix_tx_streamer #(.ROWS(2), .COLS(2), .ELEM_W(16), .ADDR_W(2), .HEADER(8'hA5)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .rd_addr(rd_addr_a), .rd_en(rd_en_a),
        .rd_data(rd_data_a), .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_busy(tx_busy_a),
        .busy(busy_a), .done(done_a));

    uart_matrix_tx_streamer #(.ROWS(1), .COLS(3), .ELEM_W(8), .ADDR_W(2), .HEADER(8'hA5)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .rd_addr(rd_addr_b), .rd_en(rd_en_b),
        .rd_data(rd_data_b), .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_busy(tx_busy_b),
        .busy(busy_b), .done(done_b));

    logic [15:0] mem_a [4];
    logic [7:0]  mem_b [4];

    always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    always @(posedge clk) if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];

    // UART models: busy for len cycles following each tx_start, plus a forced-busy override
    int   len_a = 10, len_b = 3, cnt_a = 0, cnt_b = 0;
    logic force_a = 1'b0;
    assign tx_busy_a = (cnt_a != 0) || force_a;
    assign tx_busy_b = (cnt_b != 0);

    logic [7:0] got_a[$], got_b[$], exp_q[$];
    logic [1:0] rdq_b[$];
    int   start_cnt_a = 0, done_cnt_a = 0, dbl_a = 0, busy_done_err = 0;
    int   done_cnt_b = 0, rd_cnt_b = 0, dbl_rd_b = 0;
    logic prev_ts_a = 1'b0, prev_rd_b = 1'b0;

    always @(negedge clk) begin
        if (tx_start_a) begin
            got_a.push_back(tx_data_a);
            start_cnt_a <= start_cnt_a + 1;
            cnt_a       <= len_a;
            if (prev_ts_a) dbl_a <= dbl_a + 1;
        end else if (cnt_a > 0) begin
            cnt_a <= cnt_a - 1;
        end
        prev_ts_a <= tx_start_a;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_a && busy_a) busy_done_err <= busy_done_err + 1;
    end

    always @(negedge clk) begin
        if (tx_start_b) begin
            got_b.push_back(tx_data_b);
            cnt_b <= len_b;
        end else if (cnt_b > 0) begin
            cnt_b <= cnt_b - 1;
        end
        if (rd_en_b) begin
            rdq_b.push_back(rd_addr_b);
            rd_cnt_b <= rd_cnt_b + 1;
            if (prev_rd_b) dbl_rd_b <= dbl_rd_b + 1;
        end
        prev_rd_b <= rd_en_b;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    int cmp_cnt = 0, err_cnt = 0;

    // Reference frame: header, each element's bytes high to low, XOR of element bytes.
    task automatic build_expected(input bit use_b);
        int unsigned n, nb, v;
        logic [7:0] cs, by;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        n  = use_b ? 3 : 4;
        nb = use_b ? 1 : 2;
        for (int unsigned e = 0; e < n; e++) begin
            v = use_b ? int'(mem_b[e]) : int'(mem_a[e]);
            for (int b = int'(nb) - 1; b >= 0; b--) begin
                by = 8'(v >> (8 * b));
                cs = cs ^ by;
                exp_q.push_back(by);
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int d0, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (done_cnt_a > d0) ok = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); #1;
        cmp_cnt++;
        if ({rd_addr_a, rd_en_a, tx_data_a, tx_start_a, busy_a, done_a} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs_a: got %h, want 0",
                     {rd_addr_a, rd_en_a, tx_data_a, tx_start_a, busy_a, done_a});
        end
        cmp_cnt++;
        if ({rd_addr_b, rd_en_b, tx_data_b, tx_start_b, busy_b, done_b} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs_b: got %h, want 0",
                     {rd_addr_b, rd_en_b, tx_data_b, tx_start_b, busy_b, done_b});
        end
        @(negedge clk) reset = 1'b0;
        repeat (5) @(negedge clk);
        cmp_cnt++;
        if ({tx_start_a, busy_a, rd_en_a, done_a} !== 4'b0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: got %b, want 0000", {tx_start_a, busy_a, rd_en_a, done_a});
        end
    endtask

    task automatic test_frame_basic();
        int s0, d0;
        bit ok;
        mem_a = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        len_a = 10;
        build_expected(1'b0);
        got_a.delete();
        s0 = start_cnt_a; d0 = done_cnt_a;
        pulse_start_a();
        #1;
        cmp_cnt++;
        if (busy_a !== 1'b1) begin
            err_cnt++; $display("FAIL busy_after_start: got %b, want 1", busy_a);
        end
        wait_done_a(d0, ok);
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL basic_done_timeout: got 0, want 1"); end
        cmp_cnt++;
        if (got_a.size() != exp_q.size()) begin
            err_cnt++; $display("FAIL basic_len: got %0d, want %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            cmp_cnt++;
            if (got_a[i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL basic_byte[%0d]: got %h, want %h", i, got_a[i], exp_q[i]);
            end
        end
        cmp_cnt++;
        if (start_cnt_a - s0 != 10 || done_cnt_a - d0 != 1) begin
            err_cnt++;
            $display("FAIL basic_pulses: got start=%0d done=%0d, want 10/1", start_cnt_a - s0, done_cnt_a - d0);
        end
        cmp_cnt++;
        if (busy_a !== 1'b0 || busy_done_err != 0 || dbl_a != 0) begin
            err_cnt++;
            $display("FAIL basic_busy_done: got busy=%b overlap=%0d dbl=%0d, want 0/0/0", busy_a, busy_done_err, dbl_a);
        end
    endtask

    task automatic test_busy_before_start();
        int s0, d0;
        bit ok;
        build_expected(1'b0);
        got_a.delete();
        force_a = 1'b1;
        s0 = start_cnt_a; d0 = done_cnt_a;
        pulse_start_a();
        repeat (50) @(negedge clk);
        cmp_cnt++;
        if (start_cnt_a != s0 || busy_a !== 1'b1) begin
            err_cnt++;
            $display("FAIL held_no_launch: got starts=%0d busy=%b, want 0/1", start_cnt_a - s0, busy_a);
        end
        force_a = 1'b0;
        wait_done_a(d0, ok);
        cmp_cnt++;
        if (!ok || got_a.size() != exp_q.size()) begin
            err_cnt++; $display("FAIL held_len: got %0d bytes, want %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            cmp_cnt++;
            if (got_a[i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL held_byte[%0d]: got %h, want %h", i, got_a[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int d0;
        bit ok;
        got_a.delete();
        d0 = done_cnt_a;
        pulse_start_a();
        repeat (20) @(negedge clk);
        pulse_start_a();
        wait_done_a(d0, ok);
        repeat (200) @(negedge clk);
        cmp_cnt++;
        if (!ok || got_a.size() != 10 || done_cnt_a - d0 != 1 || busy_a !== 1'b0) begin
            err_cnt++;
            $display("FAIL restart_ignored: got bytes=%0d done=%0d busy=%b, want 10/1/0",
                     got_a.size(), done_cnt_a - d0, busy_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        bit ok;
        build_expected(1'b0);
        got_a.delete();
        pulse_start_a();
        for (int c = 0; c < 1000 && got_a.size() < 4; c++) @(negedge clk);
        reset = 1'b1;
        #1;
        cmp_cnt++;
        if ({rd_addr_a, rd_en_a, tx_data_a, tx_start_a, busy_a, done_a} !== '0) begin
            err_cnt++;
            $display("FAIL midreset_outputs: got %h, want 0",
                     {rd_addr_a, rd_en_a, tx_data_a, tx_start_a, busy_a, done_a});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        got_a.delete();
        d0 = done_cnt_a;
        pulse_start_a();
        wait_done_a(d0, ok);
        cmp_cnt++;
        if (!ok || got_a.size() != exp_q.size()) begin
            err_cnt++; $display("FAIL midreset_len: got %0d, want %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            cmp_cnt++;
            if (got_a[i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL midreset_byte[%0d]: got %h, want %h", i, got_a[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_elem8();
        int d0;
        bit ok;
        logic [7:0] rnd;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) mem_b = '{8'hFF, 8'h0F, 8'hF0, 8'h00};
            else for (int i = 0; i < 3; i++) begin rnd = 8'($urandom); mem_b[i] = rnd; end
            len_b = (f == 0) ? 3 : int'($urandom_range(1, 8));
            build_expected(1'b1);
            got_b.delete(); rdq_b.delete();
            d0 = done_cnt_b;
            pulse_start_b();
            ok = 1'b0;
            for (int c = 0; c < 2000 && !ok; c++) begin
                @(negedge clk);
                if (done_cnt_b > d0) ok = 1'b1;
            end
            repeat (2) @(negedge clk);
            cmp_cnt++;
            if (!ok || got_b.size() != exp_q.size()) begin
                err_cnt++; $display("FAIL e8_len: got %0d, want %0d", got_b.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
                cmp_cnt++;
                if (got_b[i] !== exp_q[i]) begin
                    err_cnt++; $display("FAIL e8_byte[%0d]: got %h, want %h", i, got_b[i], exp_q[i]);
                end
            end
            cmp_cnt++;
            if (rdq_b.size() != 3 || dbl_rd_b != 0) begin
                err_cnt++; $display("FAIL e8_rd_en: got reads=%0d back2back=%0d, want 3/0", rdq_b.size(), dbl_rd_b);
            end
            for (int i = 0; i < 3 && i < rdq_b.size(); i++) begin
                cmp_cnt++;
                if (int'(rdq_b[i]) != i) begin
                    err_cnt++; $display("FAIL e8_rd_addr[%0d]: got %0d, want %0d", i, rdq_b[i], i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int s0, d0;
        bit ok;
        build_expected(1'b0);
        pulse_start_a();
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (done_a) ok = 1'b1;
        end
        got_a.delete();
        d0 = done_cnt_a;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (done_a) ok = 1'b1;
        end
        cmp_cnt++;
        if (!ok || got_a.size() != exp_q.size()) begin
            err_cnt++; $display("FAIL b2b_len: got %0d, want %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            cmp_cnt++;
            if (got_a[i] !== exp_q[i]) begin
                err_cnt++; $display("FAIL b2b_byte[%0d]: got %h, want %h", i, got_a[i], exp_q[i]);
            end
        end
        // start raised in the same cycle as done
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        s0 = start_cnt_a; d0 = done_cnt_a;
        repeat (200) @(negedge clk);
        cmp_cnt++;
        if (start_cnt_a != s0 || done_cnt_a != d0 || busy_a !== 1'b0) begin
            err_cnt++;
            $display("FAIL coincident_start: got starts=%0d dones=%0d busy=%b, want 0/0/0",
                     start_cnt_a - s0, done_cnt_a - d0, busy_a);
        end
    endtask

    task automatic test_random_frames();
        int d0;
        bit ok;
        logic [15:0] rnd;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 4; i++) begin rnd = 16'($urandom); mem_a[i] = rnd; end
            len_a = int'($urandom_range(1, 12));
            build_expected(1'b0);
            got_a.delete();
            d0 = done_cnt_a;
            pulse_start_a();
            wait_done_a(d0, ok);
            cmp_cnt++;
            if (!ok || got_a.size() != exp_q.size()) begin
                err_cnt++; $display("FAIL rand%0d_len: got %0d, want %0d", f, got_a.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
                cmp_cnt++;
                if (got_a[i] !== exp_q[i]) begin
                    err_cnt++; $display("FAIL rand%0d_byte[%0d]: got %h, want %h", f, i, got_a[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mem_a   = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        mem_b   = '{8'hFF, 8'h0F, 8'hF0, 8'h00};
        test_reset();
        test_frame_basic();
        test_busy_before_start();
        test_start_while_busy();
        test_reset_mid_frame();
        test_elem8();
        test_back_to_back();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_matrix_tx_streamer.md
Name: uart_matrix_tx_streamer

Overview:
- Streams a result matrix from on-chip memory to the host over the UART transmitter.
- Sits between the result buffer (synchronous-read RAM) and the transmit side of the UART two-way block (tx_start / tx_data_in / tx_busy).
- Each transfer is framed as: one header byte, every element MSB-byte first in row-major order, then one XOR checksum byte.
- It is the read-out counterpart of the receive-side matrix loader.

Parameters:
ROWS, 4, matrix rows (>=1)
COLS, 4, matrix columns (>=1)
ELEM_W, 16, element width in bits; must be a multiple of 8 (8..32)
ADDR_W, 4, result-RAM address width; 2**ADDR_W >= ROWS*COLS
HEADER, 8'hA5, frame header byte

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to send the whole matrix; sampled only in IDLE
rd_addr  out  ADDR_W  result-RAM read address
rd_en  out  1  result-RAM read enable
rd_data  in  ELEM_W  result-RAM data, valid exactly 1 cycle after rd_en
tx_data  out  8  byte to UART transmitter
tx_start  out  1  one-cycle pulse launching tx_data
tx_busy  in  1  UART transmitter busy
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after checksum byte transmission completes

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs are 0: rd_addr, rd_en, tx_data, tx_start, busy, done. Element counter, byte counter and checksum are also 0.
- Clock: single clock, all flops on rising clk.
- FSM states: IDLE, HDR, FETCH, LATCH, SEND, WAIT_HI, WAIT_LO, NEXT, CSUM, FIN.
- IDLE: on start=1 go to HDR. busy goes 1 next cycle. Element index=0, checksum=0.
- HDR: load HEADER into the byte register, then enter SEND. Header is excluded from the checksum.
- FETCH: drive rd_addr=index, rd_en=1 for exactly one cycle, then go to LATCH.
- LATCH: capture rd_data into the shift register. Byte counter = ELEM_W/8 - 1. Go to SEND.
- SEND: a byte is launched only when tx_busy=0. On launch, tx_data = current byte and tx_start=1 for exactly one cycle, then go to WAIT_HI. If tx_busy=1, stay in SEND with tx_start=0.
- tx_data is held stable from the tx_start cycle until the next launch.
- WAIT_HI: wait until tx_busy=1 (the transmitter raises tx_busy within 1–2 cycles of tx_start), then go to WAIT_LO. tx_start is never re-pulsed while in this state.
- WAIT_LO: wait until tx_busy=0, then go to NEXT.
- Checksum: XOR every element byte into the checksum at launch time.
- NEXT, selecting what follows:
  - After the header: go to FETCH.
  - Element bytes remaining: shift left by 8, decrement the byte counter, go to SEND.
  - Element finished and index < ROWS*COLS-1: increment index, go to FETCH.
  - Last element finished: go to CSUM.
  - After the checksum byte: go to FIN.
- CSUM: load the checksum into the byte register, then go to SEND.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Byte ordering: byte order within an element is MSB first. Element order is linear rd_addr 0..ROWS*COLS-1 (row-major).
- Frame length: total bytes per frame = 2 + ROWS*COLS*ELEM_W/8.
- start while busy=1 is ignored; it is neither queued nor does it restart the transfer.
- start in the same cycle as the done pulse is ignored. start one cycle after done is accepted.
- Reset mid-frame: immediate return to IDLE with all outputs 0. A byte already in the transmitter completes on its own. A new start re-sends from the header.
- tx_busy already high when start arrives: the header waits in SEND; no pulse is issued until tx_busy=0.

Test Plan:
- ROWS=COLS=2, ELEM_W=16, RAM={0x0102,0x0304,0x0506,0x0708}, transmitter model raises tx_busy 1 cycle after tx_start for 10 cycles -> bytes A5 01 02 03 04 05 06 07 08 08 in order, exactly 10 tx_start pulses, one done pulse, busy falls with done.
- Same RAM, tx_busy held high 50 cycles before start -> first tx_start only after tx_busy falls; byte sequence unchanged.
- Second start pulse issued 20 cycles into the frame -> ignored: still exactly 10 bytes, one done.
- Reset asserted after the 4th byte (0x03), then start -> output lines 0 during reset; new frame begins with A5 01 02…; checksum is 0x08.
- ELEM_W=8, ROWS=1, COLS=3, RAM={0xFF,0x0F,0xF0} -> bytes A5 FF 0F F0 00; rd_addr sequence 0,1,2, each with one-cycle rd_en.
- start asserted 1 cycle after done -> second complete identical frame; start coincident with done -> no frame.
